// File: rtl/riscv_divider_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : riscv_divider_if                                                   |
// | Brief  : Issue/write-back bundle between the issuing stage and the divider. |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface riscv_divider_if #(
  parameter int DataBitWidth    = 32,
  parameter int AddressBitWidth = 5
);
  logic                       start;
  logic [1:0]                 op;
  logic [DataBitWidth-1:0]    rs1_dat;
  logic [DataBitWidth-1:0]    rs2_dat;
  logic [AddressBitWidth-1:0] rd_in;
  logic                       busy;
  logic [AddressBitWidth-1:0] rd;
  logic                       rd_we;
  logic [DataBitWidth-1:0]    rd_wd;

  modport master (
    output start, op, rs1_dat, rs2_dat, rd_in,
    input  busy, rd, rd_we, rd_wd
  );

  modport slave (
    input  start, op, rs1_dat, rs2_dat, rd_in,
    output busy, rd, rd_we, rd_wd
  );
endinterface
`default_nettype wire

// File: rtl/riscv_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : riscv_divider                                                      |
// | Brief  : RV32M DIV/DIVU/REM/REMU, restoring division, one bit per clock.    |
// |          Optional macro DIVIDER_EARLY_OUT_EN: 1-cycle divide-by-zero and    |
// |          signed-overflow results.                                           |
// | Rev    : 1.0                                                                |
// +-----------------------------------------------------------------------------+
module riscv_divider #(
  parameter int DataBitWidth    = 32,
  parameter int AddressBitWidth = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  riscv_divider_if.slave bus
);
  localparam int c_CNT_WIDTH = $clog2(DataBitWidth) + 1;
  localparam logic [c_CNT_WIDTH-1:0] c_LAST_ITER = c_CNT_WIDTH'(DataBitWidth - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  logic                       r_busy;
  logic                       r_rd_we;
  logic [AddressBitWidth-1:0] r_rd;
  logic [DataBitWidth-1:0]    r_rd_wd;
  logic [AddressBitWidth-1:0] r_rd_lat;
  logic [c_CNT_WIDTH-1:0]     r_cnt;
  logic [DataBitWidth:0]      r_rem;
  logic [DataBitWidth-1:0]    r_quo;
  logic [DataBitWidth-1:0]    r_divisor;
  logic                       r_is_rem;
  logic                       r_neg_q;
  logic                       r_neg_r;
  logic                       r_div_zero;

  logic                       w_a_neg;
  logic                       w_b_neg;
  logic                       w_div_zero;
  logic [DataBitWidth-1:0]    w_a_mag;
  logic [DataBitWidth-1:0]    w_b_mag;
  logic [DataBitWidth+1:0]    w_rem_shift;
  logic [DataBitWidth+1:0]    w_diff;
  logic [DataBitWidth:0]      w_rem_next;
  logic [DataBitWidth-1:0]    w_quo_next;
  logic [DataBitWidth-1:0]    w_quo_res;
  logic [DataBitWidth-1:0]    w_rem_res;
  logic [DataBitWidth-1:0]    w_result;

  always_comb begin
    w_a_neg    = ~bus.op[0] & bus.rs1_dat[DataBitWidth-1];
    w_b_neg    = ~bus.op[0] & bus.rs2_dat[DataBitWidth-1];
    w_a_mag    = w_a_neg ? -bus.rs1_dat : bus.rs1_dat;
    w_b_mag    = w_b_neg ? -bus.rs2_dat : bus.rs2_dat;
    w_div_zero = (bus.rs2_dat == '0);

    // Dividend bits stream out of the quotient register's MSB into the remainder.
    w_rem_shift = {r_rem, r_quo[DataBitWidth-1]};
    w_diff      = w_rem_shift - {2'b00, r_divisor};
    if (w_diff[DataBitWidth+1]) begin
      w_rem_next = w_rem_shift[DataBitWidth:0];
      w_quo_next = {r_quo[DataBitWidth-2:0], 1'b0};
    end else begin
      w_rem_next = w_diff[DataBitWidth:0];
      w_quo_next = {r_quo[DataBitWidth-2:0], 1'b1};
    end

    // Signed overflow and the zero-divisor remainder fall out of the sign fix-up;
    // only the zero-divisor quotient needs forcing.
    w_quo_res = r_div_zero ? '1 : (r_neg_q ? -w_quo_next : w_quo_next);
    w_rem_res = r_neg_r ? -w_rem_next[DataBitWidth-1:0] : w_rem_next[DataBitWidth-1:0];
    w_result  = r_is_rem ? w_rem_res : w_quo_res;
  end

`ifdef DIVIDER_EARLY_OUT_EN
  localparam logic [DataBitWidth-1:0] c_MIN_INT = {1'b1, {(DataBitWidth-1){1'b0}}};
  logic                    w_ovf;
  logic [DataBitWidth-1:0] w_early_res;

  always_comb begin
    w_ovf = ~bus.op[0] & (bus.rs1_dat == c_MIN_INT) & (bus.rs2_dat == '1);
    if (w_div_zero) begin
      w_early_res = bus.op[1] ? bus.rs1_dat : '1;
    end else begin
      w_early_res = bus.op[1] ? '0 : bus.rs1_dat;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_rd_we    <= 1'b0;
      r_rd       <= '0;
      r_rd_wd    <= '0;
      r_rd_lat   <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_rd_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy     <= 1'b1;
            r_rd_lat   <= bus.rd_in;
            r_is_rem   <= bus.op[1];
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= w_div_zero;
            r_divisor  <= w_b_mag;
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_cnt      <= '0;
`ifdef DIVIDER_EARLY_OUT_EN
            if (w_div_zero || w_ovf) begin
              r_state <= S_DONE;
              r_rd_we <= 1'b1;
              r_rd    <= bus.rd_in;
              r_rd_wd <= w_early_res;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_ITER) begin
            r_state <= S_DONE;
            r_rd_we <= 1'b1;
            r_rd    <= r_rd_lat;
            r_rd_wd <= w_result;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.rd    = r_rd;
  assign bus.rd_we = r_rd_we;
  assign bus.rd_wd = r_rd_wd;
endmodule
`default_nettype wire
